buslist_rom: RTL and testbench

//  Column-serial glyph ROM for the karaoke scroller: streams one pre-rendered

---
 rtl/buslist_rom_if.sv | 30 +++
 rtl/buslist_rom.sv | 76 +++++++
 tb/tb_buslist_rom.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/buslist_rom_if.sv
// Column-stream bus for buslist_rom: advance strobe from the consumer, glyph
// column plus position indices and frame/end flags from the ROM.
interface buslist_rom_if #(
  parameter int CHAR_H = 8,
  parameter int CHAR_W = 6,
  parameter int CPSBLN = 16,
  parameter int DEPTH  = 1024
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CHAR_W);
  localparam int NW = $clog2(CPSBLN);

  logic              en;
  logic [CHAR_H-1:0] col_data;
  logic [AW-1:0]     addr;
  logic [CW-1:0]     col_idx;
  logic [NW-1:0]     char_idx;
  logic              line_end;
  logic              done;

  modport master (
    output en,
    input  col_data, addr, col_idx, char_idx, line_end, done
  );

  modport slave (
    input  en,
    output col_data, addr, col_idx, char_idx, line_end, done
  );
endinterface

// File: rtl/buslist_rom.sv
// Column-serial glyph ROM: streams one CHAR_H-bit column per enabled clock.
// Build option BUSLIST_ROM_WRAP_EN: loop back to word 0 instead of stopping at the end.
module buslist_rom #(
  parameter string FILENAME = "buslist.txt",
  parameter int    CHAR_H   = 8,
  parameter int    CHAR_W   = 6,
  parameter int    CPSBLN   = 16,
  parameter int    DEPTH    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  buslist_rom_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CHAR_W);
  localparam int NW = $clog2(CPSBLN);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(CHAR_W - 1);
  localparam logic [NW-1:0] CHAR_LAST = NW'(CPSBLN - 1);

  logic [CHAR_H-1:0] mem [0:DEPTH-1];

  logic [CHAR_H-1:0] data_q;
  logic [AW-1:0]     addr_q, addr_nxt;
  logic [CW-1:0]     col_q, col_nxt;
  logic [NW-1:0]     char_q, char_nxt;
  logic              line_end_q;
  logic              done_q;
  logic              at_last;
  logic              step;

  always_comb begin
    at_last  = (addr_q == ADDR_LAST);
`ifdef BUSLIST_ROM_WRAP_EN
    step     = bus.en;
    addr_nxt = at_last ? '0 : addr_q + 1'b1;
`else
    // Once the last word is on the output the stream freezes until reset.
    step     = bus.en && !at_last;
    addr_nxt = addr_q + 1'b1;
`endif
    col_nxt  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    char_nxt = char_q;
    if (col_q == COL_LAST) begin
      char_nxt = (char_q == CHAR_LAST) ? '0 : char_q + 1'b1;
    end
  end

  // Registered output stage: the read of the next word is issued together
  // with the counter update so col_data always matches addr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      col_q      <= '0;
      char_q     <= '0;
      line_end_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= mem[0];
    end else if (step) begin
      addr_q     <= addr_nxt;
      col_q      <= col_nxt;
      char_q     <= char_nxt;
      line_end_q <= (col_nxt == COL_LAST) && (char_nxt == CHAR_LAST);
      done_q     <= done_q | (addr_nxt == ADDR_LAST);
      data_q     <= mem[addr_nxt];
    end
  end

  assign bus.col_data = data_q;
  assign bus.addr     = addr_q;
  assign bus.col_idx  = col_q;
  assign bus.char_idx = char_q;
  assign bus.line_end = line_end_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_buslist_rom.sv
// Bench for buslist_rom: table-driven sequence on a full-depth instance plus an
// end-of-image sequence on a 16-word instance, every cycle scoreboarded.
module tb_buslist_rom;
`ifdef BUSLIST_ROM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  buslist_rom_if #(.DEPTH(1024)) bus0 ();
  buslist_rom_if #(.DEPTH(16))   bus1 ();

  buslist_rom #(.FILENAME(""), .DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  buslist_rom #(.FILENAME(""), .DEPTH(16)) dut16 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  typedef struct {
    logic [7:0] data;
    int         addr;
    int         col;
    int         chr;
    bit         le;
    bit         done;
  } exp_t;

  typedef struct {
    bit         rst;
    bit         en;
    int         n;
    logic [7:0] data;
    int         addr;
    int         col;
    int         chr;
    bit         le;
    bit         done;
  } vec_t;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_addr [2];
  int m_col  [2];
  int m_chr  [2];
  bit m_done [2];
  int depth  [2] = '{1024, 16};

  function automatic logic [7:0] img(int i);
    logic [31:0] v;
    v = i;
    return (i == 0) ? 8'hA5 : v[7:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int k, bit r, bit e, output exp_t x);
    if (!r) begin
      m_addr[k] = 0; m_col[k] = 0; m_chr[k] = 0; m_done[k] = 1'b0;
    end else if (e && (WRAP || m_addr[k] != depth[k] - 1)) begin
      m_addr[k] = (m_addr[k] == depth[k] - 1) ? 0 : m_addr[k] + 1;
      if (m_col[k] == 5) begin
        m_col[k] = 0;
        m_chr[k] = (m_chr[k] == 15) ? 0 : m_chr[k] + 1;
      end else begin
        m_col[k] = m_col[k] + 1;
      end
      if (m_addr[k] == depth[k] - 1) m_done[k] = 1'b1;
    end
    x.data = img(m_addr[k]);
    x.addr = m_addr[k];
    x.col  = m_col[k];
    x.chr  = m_chr[k];
    x.le   = (m_col[k] == 5) && (m_chr[k] == 15);
    x.done = m_done[k];
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, compare.
  task automatic apply(int k, bit r, bit e);
    exp_t x;
    if (k == 0) begin rst0 = r; bus0.en = e; end
    else        begin rst1 = r; bus1.en = e; end
    model_step(k, r, e, x);
    if (k == 0) q0.push_back(x); else q1.push_back(x);
    @(negedge clk);
    if (k == 0) begin
      x = q0.pop_front();
      chk("sb0_data", 32'(bus0.col_data), 32'(x.data));
      chk("sb0_addr", 32'(bus0.addr), x.addr);
      chk("sb0_col",  32'(bus0.col_idx), x.col);
      chk("sb0_char", 32'(bus0.char_idx), x.chr);
      chk("sb0_le",   32'(bus0.line_end), 32'(x.le));
      chk("sb0_done", 32'(bus0.done), 32'(x.done));
    end else begin
      x = q1.pop_front();
      chk("sb1_data", 32'(bus1.col_data), 32'(x.data));
      chk("sb1_addr", 32'(bus1.addr), x.addr);
      chk("sb1_col",  32'(bus1.col_idx), x.col);
      chk("sb1_char", 32'(bus1.char_idx), x.chr);
      chk("sb1_le",   32'(bus1.line_end), 32'(x.le));
      chk("sb1_done", 32'(bus1.done), 32'(x.done));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    bus0.en = 1'b0;
    bus1.en = 1'b0;
    for (int i = 0; i < 1024; i++) dut.mem[i] = img(i);
    for (int i = 0; i < 16; i++)   dut16.mem[i] = img(i);

    tbl[0]  = '{0, 0,  2, 8'hA5,  0, 0,  0, 0, 0};  // reset
    tbl[1]  = '{1, 1,  5, 8'h05,  5, 5,  0, 0, 0};  // stream
    tbl[2]  = '{1, 1,  1, 8'h06,  6, 0,  1, 0, 0};  // column wrap
    tbl[3]  = '{1, 1,  1, 8'h07,  7, 1,  1, 0, 0};
    tbl[4]  = '{1, 0, 10, 8'h07,  7, 1,  1, 0, 0};  // stall
    tbl[5]  = '{0, 1,  1, 8'hA5,  0, 0,  0, 0, 0};  // reset beats en
    tbl[6]  = '{1, 1, 95, 8'h5F, 95, 5, 15, 1, 0};  // last column of frame
    tbl[7]  = '{1, 1,  1, 8'h60, 96, 0,  0, 0, 0};  // next frame
    tbl[8]  = '{0, 0,  1, 8'hA5,  0, 0,  0, 0, 0};
    tbl[9]  = '{1, 1, 40, 8'h28, 40, 4,  6, 0, 0};
    tbl[10] = '{0, 1,  1, 8'hA5,  0, 0,  0, 0, 0};  // mid-stream reset

    @(negedge clk);
    for (int v = 0; v < 11; v++) begin
      for (int c = 0; c < tbl[v].n; c++) apply(0, tbl[v].rst, tbl[v].en);
      chk($sformatf("vec%0d_data", v), 32'(bus0.col_data), 32'(tbl[v].data));
      chk($sformatf("vec%0d_addr", v), 32'(bus0.addr), tbl[v].addr);
      chk($sformatf("vec%0d_col", v),  32'(bus0.col_idx), tbl[v].col);
      chk($sformatf("vec%0d_char", v), 32'(bus0.char_idx), tbl[v].chr);
      chk($sformatf("vec%0d_le", v),   32'(bus0.line_end), 32'(tbl[v].le));
      chk($sformatf("vec%0d_done", v), 32'(bus0.done), 32'(tbl[v].done));
    end
    rst0 = 1'b1;
    bus0.en = 1'b0;

    // End of image on the 16-word instance.
    apply(1, 1'b0, 1'b0);
    apply(1, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      apply(1, 1'b1, 1'b1);
      if (c == 14) chk("end_done_before", 32'(bus1.done), 0);
      if (c == 15) begin
        chk("end_addr_last", 32'(bus1.addr), 15);
        chk("end_done_set", 32'(bus1.done), 1);
        chk("end_data_last", 32'(bus1.col_data), 32'h0F);
      end
    end
    chk("end_done_sticky", 32'(bus1.done), 1);
    chk("end_addr_final", 32'(bus1.addr), WRAP ? 4 : 15);
    chk("end_data_final", 32'(bus1.col_data), WRAP ? 32'h04 : 32'h0F);
    // Reset clears the end state.
    apply(1, 1'b0, 1'b1);
    chk("end_reset_addr", 32'(bus1.addr), 0);
    chk("end_reset_done", 32'(bus1.done), 0);
    apply(1, 1'b1, 1'b1);
    chk("end_restart_addr", 32'(bus1.addr), 1);
    bus1.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
